dsss_spreader: RTL and testbench

- Direct-sequence spreader sitting directly downstream of the 12-bit PN generator (pn_gen) in the transmitter.
- Accepts payload bits through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Aligns the start of each burst to the PN period boundary (pn_roll), then XORs each data bit with CHIPS_PER_BIT consecutive PN chips.
- Emits a registered chip stream to the modulator.

---
 rtl/dsss_spreader_if.sv | 34 +++
 rtl/dsss_spreader.sv | 141 ++++++++++++++
 tb/tb_dsss_spreader.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsss_spreader_if.sv
// dsss_spreader_if
//   Bundles every non-clock signal of the DSSS spreader.
//   master : upstream side (pn_gen chip feed + payload source), and it observes the chip stream.
//   slave  : the spreader itself.
//   Signals:
//     pn_out, pn_roll        PN chip and PN-period-start marker from pn_gen
//     data_in, data_valid    payload bit and its qualifier
//     data_ready             spreader can take a payload bit this cycle
//     chip_out, chip_valid   registered spread chip and its qualifier
//     bit_start              chip_out is chip 0 of a data bit
//     busy                   spreader is armed or spreading
//     eob                    one-cycle end-of-burst pulse
interface dsss_spreader_if;
    logic pn_out;
    logic pn_roll;
    logic data_in;
    logic data_valid;
    logic data_ready;
    logic chip_out;
    logic chip_valid;
    logic bit_start;
    logic busy;
    logic eob;

    modport master (
        output pn_out, pn_roll, data_in, data_valid,
        input  data_ready, chip_out, chip_valid, bit_start, busy, eob
    );

    modport slave (
        input  pn_out, pn_roll, data_in, data_valid,
        output data_ready, chip_out, chip_valid, bit_start, busy, eob
    );
endinterface

// File: rtl/dsss_spreader.sv
// dsss_spreader
//   Direct-sequence spreader placed behind the 12-bit PN generator. Payload
//   bits are buffered in a 2-entry FIFO. A burst starts on the first chip of
//   a PN period (pn_roll). Each bit is then XORed with CHIPS_PER_BIT
//   consecutive PN chips. Queued bits follow back-to-back with no gap.
//   Ports:
//     clock   system clock, rising edge
//     reset   asynchronous, active-low
//     sp      dsss_spreader_if.slave:
//               in : pn_out, pn_roll, data_in, data_valid
//               out: data_ready, chip_out, chip_valid, bit_start, busy, eob
//   Chip outputs are registered, so they appear one cycle after the chip cycle.
module dsss_spreader #(
    parameter int CHIPS_PER_BIT = 4095,
    parameter int CNT_W         = 12
) (
    input  logic           clock,
    input  logic           reset,
    dsss_spreader_if.slave sp
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_SPREAD = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(CHIPS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] chip_cnt;
    logic [CNT_W-1:0] chip_cnt_nxt;
    logic [1:0]       fifo_count;
    logic [1:0]       fifo_mem;      // [0] is the head (bit being spread)
    logic             push;
    logic             pop;
    logic             chip_cycle;
    logic             first_chip;
    logic             last_chip;
    logic             cur_bit;

    logic             chip_p1;
    logic             vld_p1;
    logic             bit_start_p1;
    logic             eob_p1;
    logic             busy_p1;

    always_comb begin
        cur_bit    = fifo_mem[0];
        push       = sp.data_valid && (fifo_count < 2'd2);
        // The ARM cycle that sees pn_roll is itself chip 0 of the burst.
        chip_cycle = ((state == ST_ARM) && sp.pn_roll) || (state == ST_SPREAD);
        first_chip = chip_cycle && ((state == ST_ARM) || (chip_cnt == '0));
        last_chip  = (state == ST_SPREAD) && (chip_cnt == LAST_CHIP);
        pop        = last_chip;

        state_nxt    = state;
        chip_cnt_nxt = chip_cnt;
        case (state)
            ST_IDLE: begin
                if (fifo_count != 2'd0) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (sp.pn_roll) begin
                    state_nxt    = ST_SPREAD;
                    chip_cnt_nxt = CNT_ONE;
                end
            end
            ST_SPREAD: begin
                // pn_roll is deliberately ignored here: no mid-burst resync.
                if (last_chip) begin
                    chip_cnt_nxt = '0;
                    // Only a second queued bit keeps the burst going; the
                    // head being popped this cycle does not count.
                    if (fifo_count != 2'd2) begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    chip_cnt_nxt = chip_cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                chip_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            chip_cnt   <= '0;
            fifo_count <= 2'd0;
        end else begin
            state    <= state_nxt;
            chip_cnt <= chip_cnt_nxt;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage is qualified by fifo_count, so it needs no reset.
    always_ff @(posedge clock) begin
        if (pop) begin
            // Simultaneous push into a 1-deep FIFO lands straight in the head.
            fifo_mem[0] <= (push && (fifo_count == 2'd1)) ? sp.data_in : fifo_mem[1];
        end else if (push) begin
            fifo_mem[fifo_count[0]] <= sp.data_in;
        end
    end

    // Stage p1: registered chip stream
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chip_p1      <= 1'b0;
            vld_p1       <= 1'b0;
            bit_start_p1 <= 1'b0;
            eob_p1       <= 1'b0;
            busy_p1      <= 1'b0;
        end else begin
            chip_p1      <= chip_cycle ? (cur_bit ^ sp.pn_out) : 1'b0;
            vld_p1       <= chip_cycle;
            bit_start_p1 <= first_chip;
            eob_p1       <= last_chip && (fifo_count != 2'd2);
            busy_p1      <= (state_nxt != ST_IDLE);
        end
    end

    assign sp.data_ready = (fifo_count < 2'd2);
    assign sp.chip_out   = chip_p1;
    assign sp.chip_valid = vld_p1;
    assign sp.bit_start  = bit_start_p1;
    assign sp.eob        = eob_p1;
    assign sp.busy       = busy_p1;

endmodule

// File: tb/tb_dsss_spreader.sv
// tb_dsss_spreader
//   Two spreader instances: a full-period one (4095 chips/bit) fed by an LFSR
//   PN source, and a short one (7 chips/bit) fed by random chips with a short
//   pn_roll period. A queue-based reference model predicts every output.
module tb_dsss_spreader;

    localparam int PHB = 64;

    logic clock;
    logic reset;

    dsss_spreader_if ifa ();
    dsss_spreader_if ifb ();

    dsss_spreader #(.CHIPS_PER_BIT(4095), .CNT_W(12)) dut_long (
        .clock (clock),
        .reset (reset),
        .sp    (ifa)
    );

    dsss_spreader #(.CHIPS_PER_BIT(7), .CNT_W(3)) dut_short (
        .clock (clock),
        .reset (reset),
        .sp    (ifb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [11:0] lfsr;
    int          pha;
    int          phb;
    logic        pna_prev, rolla_prev, pnb_prev, rollb_prev;

    // Reference model: per instance a bit queue (max 2), a mode
    // (0 idle, 1 waiting for pn_roll, 2 spreading) and the chip index.
    int          cpb [2] = '{4095, 7};
    logic        m_q [2][$];
    int          m_mode [2];
    int          m_idx [2];
    logic [5:0]  m_exp [2];   // {chip_valid, chip_out, bit_start, eob, busy, data_ready}

    wire [5:0] obs_a = {ifa.chip_valid, ifa.chip_out, ifa.bit_start, ifa.eob, ifa.busy, ifa.data_ready};
    wire [5:0] obs_b = {ifb.chip_valid, ifb.chip_out, ifb.bit_start, ifb.eob, ifb.busy, ifb.data_ready};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_q[d].delete();
            m_mode[d] = 0;
            m_idx[d]  = 0;
            m_exp[d]  = 6'b000001;
        end
    endtask

    task automatic model_step(input int d, input logic pn, input logic roll,
                              input logic din, input logic dv);
        logic chip, last, push;
        int   idx_now;
        chip    = (m_mode[d] == 1 && roll) || (m_mode[d] == 2);
        idx_now = (m_mode[d] == 2) ? m_idx[d] : 0;
        last    = chip && (idx_now == cpb[d] - 1);
        push    = dv && (m_q[d].size() < 2);
        m_exp[d][5] = chip;
        m_exp[d][4] = chip ? (m_q[d][0] ^ pn) : 1'b0;
        m_exp[d][3] = chip && (idx_now == 0);
        m_exp[d][2] = last && (m_q[d].size() < 2);
        case (m_mode[d])
            0: if (m_q[d].size() > 0) m_mode[d] = 1;
            1: if (roll) begin m_mode[d] = 2; m_idx[d] = 1; end
            default: begin
                if (last) begin
                    if (m_q[d].size() < 2) m_mode[d] = 0;
                    m_idx[d] = 0;
                end else begin
                    m_idx[d] = m_idx[d] + 1;
                end
            end
        endcase
        if (last) void'(m_q[d].pop_front());
        if (push) m_q[d].push_back(din);
        m_exp[d][1] = (m_mode[d] != 0);
        m_exp[d][0] = (m_q[d].size() < 2);
    endtask

    // Advance one clock: model sees the inputs sampled at the edge, then the
    // PN sources move on 2 time units after the edge.
    task automatic tick();
        @(posedge clock);
        pna_prev   = ifa.pn_out;
        rolla_prev = ifa.pn_roll;
        pnb_prev   = ifb.pn_out;
        rollb_prev = ifb.pn_roll;
        if (!reset) begin
            model_reset();
        end else begin
            model_step(0, ifa.pn_out, ifa.pn_roll, ifa.data_in, ifa.data_valid);
            model_step(1, ifb.pn_out, ifb.pn_roll, ifb.data_in, ifb.data_valid);
        end
        #2;
        lfsr = {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
        pha  = (pha + 1) % 4095;
        phb  = (phb + 1) % PHB;
        ifa.pn_out  = lfsr[0];
        ifa.pn_roll = (pha == 0);
        ifb.pn_out  = 1'($urandom);
        ifb.pn_roll = (phb == 0);
    endtask

    task automatic test_reset();
        logic seen;
        int   nch;
        tick();
        tick();
        checks++;
        if ({obs_a, obs_b} !== 12'b000001_000001) begin
            failures++;
            $display("FAIL reset_state actual=%b required=%b", {obs_a, obs_b}, 12'b000001_000001);
        end
        reset = 1'b1;
        ifb.data_valid = 1'b1;
        ifb.data_in    = 1'($urandom);
        tick();
        ifb.data_in    = 1'($urandom);
        tick();
        ifb.data_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            checks++;
            if ({obs_a, obs_b} !== {m_exp[0], m_exp[1]}) begin
                failures++;
                $display("FAIL reset_fill t=%0t actual=%b required=%b", $time, {obs_a, obs_b}, {m_exp[0], m_exp[1]});
            end
            if (ifb.chip_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL reset_burst_start actual=no_chip required=chip_within_200");
        end
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({ifb.chip_valid, ifb.busy, ifb.data_ready} !== 3'b001) begin
            failures++;
            $display("FAIL reset_async actual=%b required=001", {ifb.chip_valid, ifb.busy, ifb.data_ready});
        end
        model_reset();
        tick();
        tick();
        reset = 1'b1;
        nch = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            checks++;
            if ({obs_a, obs_b} !== {m_exp[0], m_exp[1]}) begin
                failures++;
                $display("FAIL reset_after t=%0t actual=%b required=%b", $time, {obs_a, obs_b}, {m_exp[0], m_exp[1]});
            end
            if (ifb.chip_valid) nch++;
        end
        checks++;
        if (nch != 0) begin
            failures++;
            $display("FAIL reset_flush chips=%0d required=0", nch);
        end
    endtask

    task automatic test_single_long();
        int   nch, nbs, done;
        logic eob_seen;
        ifa.data_in    = 1'b1;
        ifa.data_valid = 1'b1;
        tick();
        ifa.data_valid = 1'b0;
        nch = 0; nbs = 0; done = 0; eob_seen = 1'b0;
        for (int i = 0; i < 9000 && done < 3; i++) begin
            tick();
            checks++;
            if ({obs_a, obs_b} !== {m_exp[0], m_exp[1]}) begin
                failures++;
                $display("FAIL single_model t=%0t actual=%b required=%b", $time, {obs_a, obs_b}, {m_exp[0], m_exp[1]});
            end
            if (ifa.chip_valid) begin
                nch++;
                checks++;
                if (ifa.chip_out !== ~pna_prev) begin
                    failures++;
                    $display("FAIL single_chip n=%0d actual=%b required=%b", nch, ifa.chip_out, ~pna_prev);
                end
                if (ifa.bit_start) begin
                    nbs++;
                    checks++;
                    if (rolla_prev !== 1'b1) begin
                        failures++;
                        $display("FAIL single_align actual=roll%b required=roll1", rolla_prev);
                    end
                end
            end
            if (eob_seen) done++;
            if (ifa.eob) eob_seen = 1'b1;
        end
        checks++;
        if (nch != 4095 || nbs != 1 || !eob_seen || ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_totals actual=chips%0d/starts%0d/eob%b/busy%b required=4095/1/1/0", nch, nbs, eob_seen, ifa.busy);
        end
    endtask

    task automatic test_alignment();
        int   nch, first_j, done;
        logic eob_seen;
        for (int i = 0; i < 5000 && pha != 4095 - 1000; i++) begin
            tick();
            checks++;
            if ({obs_a, obs_b} !== {m_exp[0], m_exp[1]}) begin
                failures++;
                $display("FAIL align_wait t=%0t actual=%b required=%b", $time, {obs_a, obs_b}, {m_exp[0], m_exp[1]});
            end
        end
        ifa.data_in    = 1'b0;
        ifa.data_valid = 1'b1;
        tick();
        ifa.data_valid = 1'b0;
        nch = 0; first_j = -1; done = 0; eob_seen = 1'b0;
        for (int j = 1; j < 6000 && done < 2; j++) begin
            tick();
            checks++;
            if ({obs_a, obs_b} !== {m_exp[0], m_exp[1]}) begin
                failures++;
                $display("FAIL align_model t=%0t actual=%b required=%b", $time, {obs_a, obs_b}, {m_exp[0], m_exp[1]});
            end
            if (ifa.chip_valid) begin
                if (first_j < 0) first_j = j;
                nch++;
                checks++;
                if (ifa.chip_out !== pna_prev) begin
                    failures++;
                    $display("FAIL align_chip n=%0d actual=%b required=%b", nch, ifa.chip_out, pna_prev);
                end
            end
            if (eob_seen) done++;
            if (ifa.eob) eob_seen = 1'b1;
        end
        checks++;
        if (first_j != 1000 || nch != 4095 || !eob_seen) begin
            failures++;
            $display("FAIL align_totals actual=first%0d/chips%0d/eob%b required=1000/4095/1", first_j, nch, eob_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic bits [3];
        logic acc, gap, eob_seen;
        int   k, nch;
        bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1;
        k = 0; nch = 0; gap = 1'b0; eob_seen = 1'b0;
        ifb.data_in    = bits[0];
        ifb.data_valid = 1'b1;
        for (int i = 0; i < 400 && !eob_seen; i++) begin
            acc = ifb.data_valid && ifb.data_ready;
            tick();
            checks++;
            if ({obs_a, obs_b} !== {m_exp[0], m_exp[1]}) begin
                failures++;
                $display("FAIL b2b_model t=%0t actual=%b required=%b", $time, {obs_a, obs_b}, {m_exp[0], m_exp[1]});
            end
            if (ifb.chip_valid && nch < 21) begin
                checks++;
                if ((ifb.chip_out ^ pnb_prev) !== bits[nch / 7] || ifb.bit_start !== (nch % 7 == 0)) begin
                    failures++;
                    $display("FAIL b2b_chip n=%0d actual=bit%b/start%b required=bit%b/start%b",
                             nch, ifb.chip_out ^ pnb_prev, ifb.bit_start, bits[nch / 7], (nch % 7 == 0));
                end
                nch++;
            end else if (nch > 0 && nch < 21) begin
                gap = 1'b1;
            end
            if (ifb.eob) eob_seen = 1'b1;
            if (acc) begin
                k++;
                if (k < 3) ifb.data_in = bits[k];
                else ifb.data_valid = 1'b0;
            end
        end
        ifb.data_valid = 1'b0;
        checks++;
        if (nch != 21 || gap || !eob_seen || k != 3) begin
            failures++;
            $display("FAIL b2b_totals actual=chips%0d/gap%b/eob%b/pushed%0d required=21/0/1/3", nch, gap, eob_seen, k);
        end
    endtask

    task automatic test_backpressure();
        logic bits [3];
        logic acc, eob_seen;
        int   k, nch, stalls, acc3_at;
        for (int b = 0; b < 3; b++) bits[b] = 1'($urandom);
        k = 0; nch = 0; stalls = 0; acc3_at = -1; eob_seen = 1'b0;
        ifb.data_in    = bits[0];
        ifb.data_valid = 1'b1;
        for (int i = 0; i < 400 && !eob_seen; i++) begin
            acc = ifb.data_valid && ifb.data_ready;
            if (ifb.data_valid && !ifb.data_ready) stalls++;
            tick();
            checks++;
            if ({obs_a, obs_b} !== {m_exp[0], m_exp[1]}) begin
                failures++;
                $display("FAIL bp_model t=%0t actual=%b required=%b", $time, {obs_a, obs_b}, {m_exp[0], m_exp[1]});
            end
            if (ifb.chip_valid && nch < 21) begin
                checks++;
                if ((ifb.chip_out ^ pnb_prev) !== bits[nch / 7]) begin
                    failures++;
                    $display("FAIL bp_data n=%0d actual=%b required=%b", nch, ifb.chip_out ^ pnb_prev, bits[nch / 7]);
                end
                nch++;
            end
            if (ifb.eob) eob_seen = 1'b1;
            if (acc) begin
                k++;
                if (k == 3) acc3_at = nch;
                if (k < 3) ifb.data_in = bits[k];
                else ifb.data_valid = 1'b0;
            end
        end
        ifb.data_valid = 1'b0;
        checks++;
        if (stalls == 0 || acc3_at != 8 || nch != 21 || !eob_seen) begin
            failures++;
            $display("FAIL bp_totals actual=stalls%0d/acc3_at%0d/chips%0d/eob%b required=>0/8/21/1", stalls, acc3_at, nch, eob_seen);
        end
    endtask

    task automatic test_underrun_gap();
        logic b0, b1, eob_seen;
        int   nch, nbs, eobs;
        b0 = 1'($urandom);
        b1 = 1'($urandom);
        ifb.data_in    = b0;
        ifb.data_valid = 1'b1;
        tick();
        ifb.data_valid = 1'b0;
        eob_seen = 1'b0;
        for (int i = 0; i < 200 && !eob_seen; i++) begin
            tick();
            checks++;
            if ({obs_a, obs_b} !== {m_exp[0], m_exp[1]}) begin
                failures++;
                $display("FAIL gap_first t=%0t actual=%b required=%b", $time, {obs_a, obs_b}, {m_exp[0], m_exp[1]});
            end
            if (ifb.eob) eob_seen = 1'b1;
        end
        tick();
        tick();
        ifb.data_in    = b1;
        ifb.data_valid = 1'b1;
        tick();
        ifb.data_valid = 1'b0;
        nch = 0; nbs = 0; eobs = 0;
        for (int i = 0; i < 200 && eobs == 0; i++) begin
            tick();
            checks++;
            if ({obs_a, obs_b} !== {m_exp[0], m_exp[1]}) begin
                failures++;
                $display("FAIL gap_second t=%0t actual=%b required=%b", $time, {obs_a, obs_b}, {m_exp[0], m_exp[1]});
            end
            if (ifb.chip_valid) begin
                nch++;
                if (ifb.bit_start) begin
                    nbs++;
                    checks++;
                    if (rollb_prev !== 1'b1) begin
                        failures++;
                        $display("FAIL gap_align actual=roll%b required=roll1", rollb_prev);
                    end
                end
                checks++;
                if ((ifb.chip_out ^ pnb_prev) !== b1) begin
                    failures++;
                    $display("FAIL gap_data n=%0d actual=%b required=%b", nch, ifb.chip_out ^ pnb_prev, b1);
                end
            end
            if (ifb.eob) eobs++;
        end
        checks++;
        if (!eob_seen || nch != 7 || nbs != 1 || eobs != 1) begin
            failures++;
            $display("FAIL gap_totals actual=eob1_%b/chips%0d/starts%0d/eob2_%0d required=1/7/1/1", eob_seen, nch, nbs, eobs);
        end
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 800; i++) begin
            ifb.data_valid = ($urandom_range(0, 2) == 0);
            ifb.data_in    = 1'($urandom);
            tick();
            checks++;
            if ({obs_a, obs_b} !== {m_exp[0], m_exp[1]}) begin
                failures++;
                $display("FAIL random t=%0t actual=%b required=%b", $time, {obs_a, obs_b}, {m_exp[0], m_exp[1]});
            end
        end
        ifb.data_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        ifa.data_in    = 1'b0;
        ifa.data_valid = 1'b0;
        ifb.data_in    = 1'b0;
        ifb.data_valid = 1'b0;
        lfsr           = 12'hACE;
        pha            = 0;
        phb            = 0;
        ifa.pn_out     = lfsr[0];
        ifa.pn_roll    = 1'b1;
        ifb.pn_out     = 1'b0;
        ifb.pn_roll    = 1'b1;
        pna_prev = 1'b0; rolla_prev = 1'b0; pnb_prev = 1'b0; rollb_prev = 1'b0;
        model_reset();

        test_reset();
        test_single_long();
        test_alignment();
        test_back_to_back();
        test_backpressure();
        test_underrun_gap();
        test_random_traffic();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
